mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter that acts as the responder on the processor's data-memory store/load bus.
- The core writes bytes to a small TX FIFO. An 8N1 serializer drives them onto a single serial line.
- The core polls a status register.
- Sits beside data memory in the top-level module and is selected by the top-level address decoder.

---
 rtl/mmio_uart_tx.sv | 186 ++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small TX FIFO.
// The core stores bytes to TXDATA and polls STATUS. The serializer drains the
// FIFO back-to-back, so there is no idle gap between queued frames.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | line high, waiting for the FIFO to become non-empty
// ST_START | start bit (low) for one bit time
// ST_DATA  | eight data bits, LSB first, one bit time each
// ST_STOP  | stop bit (high); pops the next byte at its end if one is queued
module mmio_uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bus_sel,
   input  logic        bus_we,
   input  logic [3:0]  bus_addr,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata,
   output logic        tx,
   output logic        tx_idle_irq
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
   localparam logic [15:0]   BIT_LOAD = 16'(CLKS_PER_BIT - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   logic [1:0]    state;
   logic [15:0]   bit_tmr;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          overflow;

   logic sel_txdata;
   logic sel_status;
   logic push_req;
   logic push;
   logic pop;
   logic clr_ovf;
   logic bit_done;
   logic fifo_empty;
   logic fifo_full;
   logic unused_bits;

   assign sel_txdata = bus_sel && (bus_addr[3:2] == 2'd0);
   assign sel_status = bus_sel && (bus_addr[3:2] == 2'd1);
   assign push_req   = sel_txdata && bus_we;
   assign clr_ovf    = sel_status && bus_we && bus_wdata[3];
   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == DEPTH_C);
   // Bit timer is a down-counter; a bit time ends on its terminal count.
   assign bit_done   = (bit_tmr == 16'd0);
   assign pop        = !fifo_empty &&
                       ((state == ST_IDLE) || ((state == ST_STOP) && bit_done));
   // A full FIFO still takes a byte when the serializer frees a slot this edge.
   assign push       = push_req && (!fifo_full || pop);
   assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:8]};

   assign tx_idle_irq = fifo_empty && (state == ST_IDLE);

   // FIFO storage: written only on an accepted push.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= bus_wdata[7:0];
      end
   end

   // FIFO pointers, occupancy and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
         if (push_req && !push) begin
            overflow <= 1'b1;
         end else if (clr_ovf) begin
            overflow <= 1'b0;
         end
      end
   end

   // Serializer FSM; tx is registered so the line never glitches.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         tx      <= 1'b1;
         bit_tmr <= 16'd0;
         bit_idx <= 3'd0;
         shift   <= 8'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               tx <= 1'b1;
               if (pop) begin
                  shift   <= fifo_mem[rd_ptr];
                  bit_tmr <= BIT_LOAD;
                  tx      <= 1'b0;
                  state   <= ST_START;
               end
            end
            ST_START: begin
               if (bit_done) begin
                  bit_tmr <= BIT_LOAD;
                  bit_idx <= 3'd0;
                  tx      <= shift[0];
                  state   <= ST_DATA;
               end else begin
                  bit_tmr <= bit_tmr - 16'd1;
               end
            end
            ST_DATA: begin
               if (bit_done) begin
                  bit_tmr <= BIT_LOAD;
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= ST_STOP;
                  end else begin
                     shift   <= shift >> 1;
                     tx      <= shift[1];
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  bit_tmr <= bit_tmr - 16'd1;
               end
            end
            ST_STOP: begin
               if (bit_done) begin
                  if (pop) begin
                     shift   <= fifo_mem[rd_ptr];
                     bit_tmr <= BIT_LOAD;
                     tx      <= 1'b0;
                     state   <= ST_START;
                  end else begin
                     tx    <= 1'b1;
                     state <= ST_IDLE;
                  end
               end else begin
                  bit_tmr <= bit_tmr - 16'd1;
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Load data: only STATUS returns non-zero; deselected reads return 0.
   always_comb begin
      bus_rdata = 32'd0;
      if (sel_status) begin
         bus_rdata[0]    = (state != ST_IDLE);
         bus_rdata[1]    = fifo_full;
         bus_rdata[2]    = fifo_empty;
         bus_rdata[3]    = overflow;
         bus_rdata[15:8] = 8'(count);
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed scenarios plus random bus traffic against a
// queue-and-frame-timer reference model and a line-sampling UART receiver.
module tb_mmio_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;

   logic        clk = 1'b0;
   logic        rst;
   logic        bus_sel;
   logic        bus_we;
   logic [3:0]  bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        tx;
   logic        tx_idle_irq;

   always #5 clk = ~clk;

   mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus_sel     (bus_sel),
      .bus_we      (bus_we),
      .bus_addr    (bus_addr),
      .bus_wdata   (bus_wdata),
      .bus_rdata   (bus_rdata),
      .tx          (tx),
      .tx_idle_irq (tx_idle_irq)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: pending bytes, byte on the wire, cycles left in frame.
   logic [7:0] mq[$];
   logic [7:0] exp_log[$];
   logic [7:0] rxq[$];
   logic [7:0] cur   = 8'd0;
   int         rem   = 0;
   logic       m_ovf = 1'b0;

   bit         rx_active = 1'b0;
   int         rx_cnt    = 0;
   logic [7:0] rx_byte   = 8'd0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic m_tx();
      int slot;
      if (rem == 0) return 1'b1;
      slot = (FRAME - rem) / CPB;
      if (slot == 0) return 1'b0;
      if (slot == 9) return 1'b1;
      return cur[slot-1];
   endfunction

   function automatic logic [31:0] m_status();
      return {16'h0, 8'(mq.size()), 4'h0, m_ovf, (mq.size() == 0),
              (mq.size() == DEPTH), (rem != 0)};
   endfunction

   task automatic cycle(input logic r, input logic s, input logic w,
                        input logic [3:0] a, input logic [31:0] d);
      logic pop_m;
      logic acc;
      logic [31:0] exp_rd;
      @(negedge clk);
      rst = r; bus_sel = s; bus_we = w; bus_addr = a; bus_wdata = d;
      #1;
      if (!(s && w)) begin
         exp_rd = (s && a[3:2] == 2'd1) ? m_status() : 32'd0;
         check("rdata", bus_rdata, exp_rd);
      end
      @(posedge clk);
      if (r) begin
         if (rem > 0) begin
            void'(exp_log.pop_back());
            if (!rx_active) void'(rxq.pop_back());
         end
         mq.delete();
         rem   = 0;
         m_ovf = 1'b0;
      end else begin
         pop_m = (rem <= 1) && (mq.size() > 0);
         acc   = (mq.size() < DEPTH) || pop_m;
         if (pop_m) begin
            cur = mq.pop_front();
            exp_log.push_back(cur);
            rem = FRAME;
         end else if (rem > 0) begin
            rem--;
         end
         if (s && w && a[3:2] == 2'd0) begin
            if (acc) mq.push_back(d[7:0]);
            else     m_ovf = 1'b1;
         end
         if (s && w && a[3:2] == 2'd1 && d[3]) m_ovf = 1'b0;
      end
      #1;
      check("tx", tx, m_tx());
      check("irq", tx_idle_irq, (rem == 0) && (mq.size() == 0));
      if (r) begin
         rx_active = 1'b0;
      end else if (!rx_active) begin
         if (tx == 1'b0) begin
            rx_active = 1'b1;
            rx_cnt    = 0;
            rx_byte   = 8'd0;
         end
      end else begin
         rx_cnt++;
         if (rx_cnt % CPB == CPB / 2) begin
            if (rx_cnt < 9 * CPB) begin
               rx_byte[rx_cnt/CPB-1] = tx;
            end else begin
               check("rx_stop", tx, 1'b1);
               rxq.push_back(rx_byte);
               rx_active = 1'b0;
            end
         end
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      cycle(1'b0, 1'b1, 1'b1, a, d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 4'h4, 32'd0);
   endtask

   // Combinational load probe, issued just after an edge.
   task automatic peek(input string tag, input logic s, input logic [3:0] a,
                       input logic [31:0] exp);
      bus_sel = s; bus_we = 1'b0; bus_addr = a;
      #1;
      check(tag, bus_rdata, exp);
   endtask

   initial begin
      int n;
      logic r, s, w;
      logic [3:0] a;
      rst = 1'b1; bus_sel = 1'b0; bus_we = 1'b0; bus_addr = 4'h0; bus_wdata = 32'd0;

      cycle(1'b1, 1'b0, 1'b0, 4'h0, 32'd0);
      cycle(1'b1, 1'b0, 1'b0, 4'h0, 32'd0);
      peek("reset_status", 1'b1, 4'h4, 32'h0000_0004);
      check("reset_tx", tx, 1'b1);
      check("reset_irq", tx_idle_irq, 1'b1);

      // Single byte, upper store bits must be ignored.
      wr(4'h0, 32'hFFFF_FF55);
      idle(1);
      check("single_start", tx, 1'b0);
      peek("single_busy", 1'b1, 4'h4, 32'h0000_0005);
      idle(39);
      check("single_irq_stop", tx_idle_irq, 1'b0);
      idle(1);
      check("single_irq_end", tx_idle_irq, 1'b1);
      idle(4);
      check("single_byte", rxq[rxq.size()-1], 32'h55);

      // Back-to-back frames.
      wr(4'h0, 32'hA5);
      wr(4'h0, 32'h3C);
      idle(85);
      check("b2b_byte0", rxq[rxq.size()-2], 32'hA5);
      check("b2b_byte1", rxq[rxq.size()-1], 32'h3C);

      // Overflow while busy, then clear.
      wr(4'h0, 32'h11);
      idle(2);
      for (int i = 0; i < 5; i++) wr(4'h0, 32'h21 + i);
      peek("ovf_status", 1'b1, 4'h4, 32'h0000_040B);
      wr(4'h4, 32'h8);
      peek("ovf_cleared", 1'b1, 4'h4, 32'h0000_0403);
      idle(5 * FRAME + 10);

      // Full FIFO, push on the exact edge the stop bit ends and pops.
      wr(4'h0, 32'h31);
      idle(2);
      for (int i = 0; i < 4; i++) wr(4'h0, 32'h32 + i);
      n = 0;
      while (rem > 1 && n < 100) begin
         idle(1);
         n++;
      end
      check("fullpop_reached", (rem == 1), 1'b1);
      wr(4'h0, 32'h36);
      peek("fullpop_status", 1'b1, 4'h4, 32'h0000_0403);
      idle(5 * FRAME + 10);

      // Reset in the middle of a frame with two bytes queued.
      wr(4'h0, 32'h41);
      wr(4'h0, 32'h42);
      wr(4'h0, 32'h43);
      idle(10);
      cycle(1'b1, 1'b0, 1'b0, 4'h0, 32'd0);
      check("rstmid_tx", tx, 1'b1);
      check("rstmid_irq", tx_idle_irq, 1'b1);
      peek("rstmid_status", 1'b1, 4'h4, 32'h0000_0004);
      idle(60);

      // Bus decode.
      peek("res_load", 1'b1, 4'h8, 32'd0);
      wr(4'hC, 32'hFFFF_FFFF);
      peek("res_store", 1'b1, 4'h4, 32'h0000_0004);
      cycle(1'b0, 1'b0, 1'b1, 4'h0, 32'h77);
      peek("nosel_rdata", 1'b0, 4'h4, 32'd0);
      idle(3);
      peek("nosel_nopush", 1'b1, 4'h4, 32'h0000_0004);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         r = ($urandom_range(0, 599) == 0);
         s = ($urandom_range(0, 7) != 0);
         n = $urandom_range(0, 31);
         w = (n < 4);
         a = (n < 2) ? 4'h0 : (n == 2) ? 4'h4 : (n == 3) ? 4'hC : 4'($urandom_range(0, 15));
         cycle(r, s, w, a, $urandom);
      end
      idle(6 * FRAME);

      check("rx_count", rxq.size(), exp_log.size());
      for (int i = 0; i < rxq.size() && i < exp_log.size(); i++)
         check("rx_byte", rxq[i], exp_log[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
